// File: rtl/nco_wavetable.sv
// nco_wavetable: wavetable numerically controlled oscillator.
// Fractional phase accumulator, programmable strobe divider, read-first table
// RAM with an independent load port and a two-cycle read pipeline to sample_o.
// Optional build macro NCO_PHASE_OFFSET_EN adds phase_off_i, a read-address
// offset that leaves the accumulator itself untouched.
module nco_wavetable #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 6000,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FRAC_W = 8,
  parameter int DIV_W  = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     sync_i,
  input  logic [DIV_W-1:0]         div_i,
  input  logic [ADDR_W+FRAC_W-1:0] tw_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [ADDR_W-1:0]        phase_off_i,
`endif
  output logic [DATA_W-1:0]        sample_o,
  output logic                     sample_valid_o,
  output logic                     err_o
);

  localparam int PW = ADDR_W + FRAC_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              err_q, err_d;
  logic              rd_v_q;
  logic              valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] sample_q;

  logic              ce;
  logic              tw_bad;
  logic              step;
  logic [PW:0]       sum;
  logic [ADDR_W:0]   sum_int;
  logic [ADDR_W:0]   wrap_int;
  logic [ADDR_W-1:0] phase_int;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ok;

  // Strobe divider: count up while enabled, fire and restart once the count reaches div_i
  always_comb begin
    ce    = 1'b0;
    cnt_d = cnt_q;
    if (sync_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_i) begin
      ce    = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  assign tw_bad    = {1'b0, tw_i[PW-1:FRAC_W]} >= DEPTH_C;
  assign step      = ce && !tw_bad;
  assign sum       = {1'b0, phase_q} + {1'b0, tw_i};
  assign sum_int   = sum[PW:FRAC_W];
  assign wrap_int  = sum_int - DEPTH_C;
  assign phase_int = phase_q[PW-1:FRAC_W];
  assign wr_ok     = {1'b0, wr_addr_i} < DEPTH_C;

  // Accumulator next state: restart on sync, advance with single-subtraction wrap on a legal strobe
  always_comb begin
    phase_d = phase_q;
    err_d   = err_q;
    if (sync_i) begin
      phase_d = '0;
    end else if (ce) begin
      if (tw_bad) begin
        err_d = 1'b1;
      end else if (sum_int >= DEPTH_C) begin
        phase_d = {wrap_int[ADDR_W-1:0], sum[FRAC_W-1:0]};
      end else begin
        phase_d = sum[PW-1:0];
      end
    end
  end

`ifdef NCO_PHASE_OFFSET_EN
  logic [ADDR_W:0] off_eff;
  logic [ADDR_W:0] addr_sum;
  logic [ADDR_W:0] addr_wrap;

  // Read address with offset folded back into the table by one conditional subtraction
  always_comb begin
    off_eff   = {1'b0, phase_off_i};
    if (off_eff >= DEPTH_C) begin
      off_eff = '0;
    end
    addr_sum  = {1'b0, phase_int} + off_eff;
    addr_wrap = addr_sum - DEPTH_C;
    rd_addr   = addr_sum[ADDR_W-1:0];
    if (addr_sum >= DEPTH_C) begin
      rd_addr = addr_wrap[ADDR_W-1:0];
    end
  end
`else
  assign rd_addr = phase_int;
`endif

  // Control state and output registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      err_q    <= 1'b0;
      rd_v_q   <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      rd_v_q  <= step;
      valid_q <= rd_v_q;
      if (rd_v_q) begin
        sample_q <= rd_data_q;
      end
    end
  end

  // Table RAM: read-first registered read on each legal strobe, out-of-range writes dropped
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_ok) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (step) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign err_o          = err_q;

endmodule

// File: doc/nco_wavetable.md
Name: nco_wavetable

Overview:
Parametrised wavetable NCO with a fractional phase accumulator, runtime strobe divider and an independent table-load port. Supersedes the fixed-step, shared-address NCO: table writes no longer disturb playback, tuning resolution is sub-sample, and the table depth need not be a power of two. Sits between the host register interface (table load, tuning) and the DAC sample path.

Parameters:
DATA_W, 8, sample width
DEPTH, 6000, table entries (any value ≥ 2)
ADDR_W, $clog2(DEPTH), table address / phase integer width
FRAC_W, 8, phase fractional bits
DIV_W, 26, strobe divider width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
en_i  in  1  run enable
sync_i  in  1  phase restart pulse
div_i  in  DIV_W  strobe period minus 1
tw_i  in  ADDR_W+FRAC_W  tuning word {integer, fraction}
wr_en_i  in  1  table write strobe
wr_addr_i  in  ADDR_W  table write address
wr_data_i  in  DATA_W  table write data
sample_o  out  DATA_W  output sample
sample_valid_o  out  1  one-cycle pulse per new sample
err_o  out  1  sticky illegal-tuning-word flag

Behaviour:
- Reset (async, rst_n low): phase accumulator 0, strobe counter 0, sample_o 0, sample_valid_o 0, err_o 0. Table RAM not reset; contents survive reset.
- Strobe: counter increments each cycle while en_i=1; ce=1 when cnt ≥ div_i, and the counter returns to 0 on that cycle. div_i=0 → ce every cycle. Lowering div_i below the current count fires ce on the next cycle. en_i=0 → counter forced to 0, no ce.
- Phase update on ce: sum = phase + tw_i (ADDR_W+FRAC_W+1 bits). If integer(sum) ≥ DEPTH, subtract DEPTH from the integer part (single subtraction; fraction carried unchanged).
- Illegal tuning word: integer(tw_i) ≥ DEPTH at a ce → phase holds, no sample issued, err_o set. err_o clears only on reset.
- sync_i=1 (priority over ce): phase ← 0, counter ← 0, no sample that cycle. Next ce reads address 0.
- Read pipeline: in a ce cycle t, read address = integer(phase) before update. RAM registered read at end of t, sample_o registered at end of t+1, sample_valid_o high for exactly cycle t+2. Latency 2 cycles, fully pipelined (div_i=0 gives one sample per cycle).
- sample_o holds its last value between valid pulses and while disabled.
- Table write: wr_en_i=1 writes wr_data_i to wr_addr_i at the clock edge, independent of en_i and ce. wr_addr_i ≥ DEPTH → write dropped. Write and read to the same address in the same cycle → read returns old data (read-first).
- Changes to tw_i take effect at the next ce; no other input sampling.

Optional Feature:
NCO_PHASE_OFFSET_EN
- Defined: adds input port phase_off_i [ADDR_W-1:0]. Read address = (integer(phase) + phase_off_i) mod DEPTH, computed with a single conditional subtraction. phase_off_i ≥ DEPTH is treated as 0. Accumulator itself is unaffected, so offset changes cause no phase drift.
- Undefined: port absent; read address = integer(phase).

Test Plan:
1. Load table[k]=k[7:0] for all k; div_i=0, tw_i=0x0100, en_i=1 → sample_o = 0,1,2,3… on consecutive cycles; first sample_valid_o 2 cycles after the first ce.
2. tw_i=0x0080 (0.5), div_i=0 → samples 0,0,1,1,2,2…; accumulator fraction alternates 0x00/0x80.
3. Wrap: sync, then tw_i=0x0700, run until phase=5999 → next samples from addresses 5999, 6, 13 (values 0x6F, 0x06, 0x0D).
4. div_i=3 → sample_valid_o pulses every 4 cycles; change div_i to 1 mid-count at cnt=2 → ce on the next cycle, then every 2 cycles.
5. tw_i integer = 6000 → err_o=1, no valid pulses, phase unchanged; restore tw_i=0x0100 → samples resume from the held phase; err_o stays 1 until rst_n pulse.
6. Reset mid-run, then run again → outputs 0 during reset, playback restarts from address 0, table contents intact. Write to address 5 while reading address 5 → old value returned that sample, new value on the next pass. With NCO_PHASE_OFFSET_EN, phase_off_i=5998, tw_i=0x0100 → samples from addresses 5998, 5999, 0, 1.
